russian_peasant_seq_multiplier: RTL and testbench
=================================================

RUSSIAN_PEASANT_SEQ_MULTIPLIER -- requirements
Module: russian_peasant_seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 Port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1, reset: synchronous, active-high.
REQ-004 Port in_valid, input, 1, operand pair offered.
REQ-005 Port in_ready, output, 1, block can accept an operand pair.
REQ-006 Port signed_mode, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled with the operands.
REQ-007 Port a, input, WIDTH, multiplier operand (the operand that is halved).
REQ-008 Port b, input, WIDTH, multiplicand operand (the operand that is doubled).
REQ-009 Port out_valid, output, 1, product available.
REQ-010 Port out_ready, input, 1, consumer accepts the product.
REQ-011 Port product, output, 2*WIDTH, result; two's-complement when the captured signed_mode = 1.

Function
REQ-012 FSM states: IDLE, RUN, DONE.
REQ-013 IDLE: in_ready = 1 and out_valid = 0.
REQ-014 Accept: in IDLE with in_valid = 1, capture the operands and the mode, then go to RUN.
REQ-015 Operand conditioning at capture: a_reg = |a| and b_reg = |b| zero-extended to 2*WIDTH, taking magnitudes only in signed mode; neg_flag = sign(a) XOR sign(b) in signed mode, else 0.
REQ-016 RUN step, per cycle: if a_reg[0] = 1 then acc += b_reg; then a_reg >>= 1, b_reg <<= 1, step_cnt += 1.
REQ-017 Early termination: leave RUN after the step in which the shifted a_reg becomes 0, or after WIDTH steps, whichever comes first.
REQ-018 RUN latency: max(1, index of the highest set bit of |a| + 1) cycles.
REQ-019 On leaving RUN, load product with acc, or with the 2*WIDTH two's-complement negation of acc if neg_flag = 1, then enter DONE.
REQ-020 DONE: out_valid = 1 and in_ready = 0; product is held stable until out_ready = 1, then go to IDLE.
REQ-021 There is no overlap: in DONE with out_ready = 1, in_ready stays 0 in that cycle, and a new operand pair is accepted no earlier than the following cycle.
REQ-022 in_valid is ignored in RUN and DONE; the operand inputs are not re-sampled.
REQ-023 Signed magnitude of the most negative value (-2^(WIDTH-1)) is held as an unsigned WIDTH-bit value without overflow; the product always fits in 2*WIDTH bits.
REQ-024 The accumulator and shifted b_reg are 2*WIDTH bits wide; there is no truncation before the product is loaded.

Reset
REQ-025 When rst = 1 at a clock edge, the next state is IDLE with in_ready = 1, out_valid = 0, product = 0, acc = 0, a_reg = 0, b_reg = 0, step_cnt = 0 and neg_flag = 0.
REQ-026 Reset in RUN or DONE aborts the operation; the pending result is discarded and is never presented.
REQ-027 rst takes priority over every handshake event in the same cycle.

Structure
REQ-028 The shared package rp_mult_pkg holds the state enum (IDLE/RUN/DONE) and a localparam function giving the counter width, clog2(WIDTH+1).
REQ-029 A single sub-module, rp_abs_neg, is used: WIDTH-bit conditional absolute value and 2*WIDTH conditional negation, instantiated once for each purpose.
REQ-030 The datapath uses one adder of width 2*WIDTH; there is no array of partial products.

Verification
REQ-031 WIDTH=8, unsigned, a=0x00, b=0xFF: one RUN cycle, then product = 0x0000 with out_valid = 1.
REQ-032 WIDTH=8, unsigned, a=0xFF, b=0xFF: eight RUN cycles, then product = 0xFE01.
REQ-033 WIDTH=8, signed, a=0x80, b=0xFF (-128 * -1): product = 0x0080; a=0x80, b=0x7F: product = 0xC080.
REQ-034 Backpressure: hold out_ready = 0 for 5 cycles in DONE; product, out_valid = 1 and in_ready = 0 stay constant, and on the first out_ready = 1 cycle the block returns to IDLE the next cycle.
REQ-035 Reset mid-operation: assert rst in the 3rd RUN cycle of a=0xFF, b=0x03; the next cycle shows in_ready = 1, out_valid = 0, product = 0, and no stale result appears afterward.
REQ-036 Randomised back-to-back sweep for WIDTH in {4, 8, 16} and both modes: every product equals the reference a*b, and every RUN latency matches REQ-018.

Source files
------------

// File: rtl/rp_mult_pkg.sv
// Shared types and helpers for the Russian-peasant sequential multiplier.
// Holds the controller state encoding and the step-counter width helper.
package rp_mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Step counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/rp_abs_neg.sv
// Conditional two's-complement negation; used both as an absolute-value
// stage (negate = operand sign) and as the final product sign fix-up.
module rp_abs_neg #(
  parameter int W = 8
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  // The most negative input maps onto itself, which read as unsigned is its magnitude.
  assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/russian_peasant_seq_multiplier.sv
// Sequential shift-and-add (Russian peasant) multiplier with valid/ready
// handshakes, signed/unsigned modes and early exit once the multiplier runs out of ones.
module russian_peasant_seq_multiplier
  import rp_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = cnt_width(WIDTH);

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     a_reg;
  logic [2*WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   acc_fixed;
  logic [CW-1:0]        step_cnt;
  logic                 neg_flag;
  logic [WIDTH-1:0]     a_abs;
  logic [WIDTH-1:0]     b_abs;
  logic                 last_step;

  rp_abs_neg #(.W(WIDTH)) u_abs_a (
    .value  (a),
    .negate (signed_mode & a[WIDTH-1]),
    .result (a_abs)
  );

  rp_abs_neg #(.W(WIDTH)) u_abs_b (
    .value  (b),
    .negate (signed_mode & b[WIDTH-1]),
    .result (b_abs)
  );

  rp_abs_neg #(.W(2*WIDTH)) u_neg_acc (
    .value  (acc_next),
    .negate (neg_flag),
    .result (acc_fixed)
  );

  // Single 2*WIDTH adder; the exit test looks at the multiplier after this step's shift.
  always_comb begin
    acc_next  = acc + (a_reg[0] ? b_reg : '0);
    last_step = ((a_reg >> 1) == '0) || (step_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture magnitudes in IDLE, one shift/add step per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      step_cnt <= '0;
      neg_flag <= 1'b0;
      product  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a_abs;
            b_reg    <= {{WIDTH{1'b0}}, b_abs};
            acc      <= '0;
            step_cnt <= '0;
            neg_flag <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        RUN: begin
          acc      <= acc_next;
          a_reg    <= a_reg >> 1;
          b_reg    <= b_reg << 1;
          step_cnt <= step_cnt + CW'(1);
          if (last_step) product <= acc_fixed;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_russian_peasant_seq_multiplier.sv
// Self-checking bench: three DUT widths (4/8/16) behind one shared stimulus bus,
// directed vectors, backpressure/reset sequences and a randomized sweep vs. a math model.
module tb_russian_peasant_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        mode;
  logic [15:0] a_bus;
  logic [15:0] b_bus;
  int          sel;

  logic        in_ready4, in_ready8, in_ready16;
  logic        out_valid4, out_valid8, out_valid16;
  logic [7:0]  product4;
  logic [15:0] product8;
  logic [31:0] product16;

  logic        cur_in_ready;
  logic        cur_out_valid;
  logic [31:0] cur_product;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  russian_peasant_seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(in_ready4),
    .signed_mode(mode), .a(a_bus[3:0]), .b(b_bus[3:0]), .out_valid(out_valid4),
    .out_ready(out_ready && sel == 0), .product(product4)
  );

  russian_peasant_seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(in_ready8),
    .signed_mode(mode), .a(a_bus[7:0]), .b(b_bus[7:0]), .out_valid(out_valid8),
    .out_ready(out_ready && sel == 1), .product(product8)
  );

  russian_peasant_seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(in_ready16),
    .signed_mode(mode), .a(a_bus), .b(b_bus), .out_valid(out_valid16),
    .out_ready(out_ready && sel == 2), .product(product16)
  );

  always_comb begin
    cur_in_ready  = in_ready8;
    cur_out_valid = out_valid8;
    cur_product   = {16'h0, product8};
    case (sel)
      0: begin cur_in_ready = in_ready4;  cur_out_valid = out_valid4;  cur_product = {24'h0, product4}; end
      2: begin cur_in_ready = in_ready16; cur_out_valid = out_valid16; cur_product = product16; end
      default: ;
    endcase
  end

  function automatic int width_of(input int s);
    return (s == 0) ? 4 : (s == 1) ? 8 : 16;
  endfunction

  // Operand value as an integer under the given mode.
  function automatic longint operand_value(input int w, input bit m, input logic [15:0] v);
    longint x;
    x = longint'(v) & ((64'sd1 <<< w) - 1);
    if (m && x[w-1]) x = x - (64'sd1 <<< w);
    return x;
  endfunction

  function automatic logic [31:0] ref_product(input int w, input bit m, input logic [15:0] av,
                                              input logic [15:0] bv);
    longint p;
    p = operand_value(w, m, av) * operand_value(w, m, bv);
    return 32'(p & ((64'sd1 <<< (2 * w)) - 1));
  endfunction

  function automatic int ref_latency(input int w, input bit m, input logic [15:0] av);
    longint mag;
    int     n;
    mag = operand_value(w, m, av);
    if (mag < 0) mag = -mag;
    n = 0;
    while (mag != 0) begin
      mag = mag >> 1;
      n++;
    end
    return (n == 0) ? 1 : n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Offer one operand pair, then count RUN cycles until out_valid; returns at a DONE negedge.
  task automatic applyStimulus(input int s, input bit m, input logic [15:0] av, input logic [15:0] bv,
                               output logic [31:0] prod, output int lat);
    @(negedge clk);
    sel      = s;
    mode     = m;
    a_bus    = av;
    b_bus    = bv;
    in_valid = 1'b1;
    #1;
    checkOutput("accept_in_ready", 32'(cur_in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_bus    = 16'($urandom);
    b_bus    = 16'($urandom);
    mode     = ~m;
    lat      = 0;
    prod     = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (cur_out_valid) break;
      lat++;
    end
    if (!cur_out_valid) begin
      checkOutput("done_timeout", 32'(cur_out_valid), 32'd1);
    end else begin
      prod = cur_product;
      checkOutput("done_in_ready", 32'(cur_in_ready), 32'd0);
    end
  endtask

  task automatic releaseOutput();
    out_ready = 1'b1;
    #1;
    checkOutput("no_overlap_ready", 32'(cur_in_ready), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    int          s;
    bit          m;
    logic [15:0] av;
    logic [15:0] bv;
    logic [31:0] exp_p;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] prod;
  int          lat;
  bit          stale;

  initial begin
    vecs.push_back('{1, 1'b0, 16'h00,   16'hFF,   32'h0000,     1});
    vecs.push_back('{1, 1'b0, 16'hFF,   16'hFF,   32'hFE01,     8});
    vecs.push_back('{1, 1'b1, 16'h80,   16'hFF,   32'h0080,     8});
    vecs.push_back('{1, 1'b1, 16'h80,   16'h7F,   32'hC080,     8});
    vecs.push_back('{1, 1'b1, 16'h00,   16'h80,   32'h0000,     1});
    vecs.push_back('{0, 1'b1, 16'h7,    16'hD,    32'hEB,       3});
    vecs.push_back('{0, 1'b0, 16'h1,    16'hF,    32'h0F,       1});
    vecs.push_back('{2, 1'b0, 16'h0100, 16'h1234, 32'h00123400, 9});
    vecs.push_back('{2, 1'b1, 16'hFFFF, 16'h0002, 32'hFFFFFFFE, 1});

    sel = 1; mode = 1'b0; a_bus = '0; b_bus = '0;
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checkOutput("reset_in_ready",  32'(cur_in_ready),  32'd1);
      checkOutput("reset_out_valid", 32'(cur_out_valid), 32'd0);
      checkOutput("reset_product",   cur_product,        32'd0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].s, vecs[i].m, vecs[i].av, vecs[i].bv, prod, lat);
      checkOutput($sformatf("vec%0d_product", i), prod, vecs[i].exp_p);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      releaseOutput();
    end

    // Backpressure: 5 stalled DONE cycles must hold everything still.
    applyStimulus(1, 1'b0, 16'h05, 16'h03, prod, lat);
    checkOutput("bp_product", prod, 32'h000F);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_product",   cur_product,        32'h000F);
      checkOutput("bp_hold_out_valid", 32'(cur_out_valid), 32'd1);
      checkOutput("bp_hold_in_ready",  32'(cur_in_ready),  32'd0);
    end
    releaseOutput();
    @(negedge clk);
    checkOutput("bp_idle_in_ready",  32'(cur_in_ready),  32'd1);
    checkOutput("bp_idle_out_valid", 32'(cur_out_valid), 32'd0);

    // Reset during the third RUN cycle discards the pending result.
    @(negedge clk);
    sel = 1; mode = 1'b0; a_bus = 16'h00FF; b_bus = 16'h0003; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid_in_ready",  32'(cur_in_ready),  32'd1);
    checkOutput("rst_mid_out_valid", 32'(cur_out_valid), 32'd0);
    checkOutput("rst_mid_product",   cur_product,        32'd0);
    stale = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cur_out_valid) stale = 1'b1;
    end
    checkOutput("rst_no_stale", 32'(stale), 32'd0);

    // Randomized back-to-back sweep over all widths and both modes.
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 60; n++) begin
        int          w;
        int          r;
        bit          m;
        logic [15:0] av;
        logic [15:0] bv;
        w  = width_of(s);
        m  = 1'($urandom);
        r  = int'($urandom_range(0, 9));
        av = 16'($urandom);
        bv = 16'($urandom);
        if (r == 0) av = '0;
        else if (r == 1) av = 16'(1 << (w - 1));
        else if (r == 2) bv = 16'(1 << (w - 1));
        applyStimulus(s, m, av, bv, prod, lat);
        checkOutput($sformatf("rand_w%0d_product", w), prod, ref_product(w, m, av, bv));
        checkOutput($sformatf("rand_w%0d_latency", w), 32'(lat), 32'(ref_latency(w, m, av)));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        releaseOutput();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
